fht_adc_loader: RTL and testbench

//  Upstream feeder of fht_top: accepts a stream of signed ADC samples and writes one
//  N-point frame (N = 4*2^A_BIT) into the 4 FHT RAM banks in bit-reversed order.

---
 rtl/fht_adc_loader.sv | 148 ++++++++++++++
 tb/tb_fht_adc_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_adc_loader.sv
// ADC stream loader for fht_top: writes one N-point frame in bit-reversed order
// across the four FHT RAM banks, then starts the transform and waits for it to finish.
module fht_adc_loader #(
  parameter int unsigned ADC_WIDTH = 16,
  parameter int unsigned D_BIT     = 22,
  parameter int unsigned A_BIT     = 8,
  parameter int unsigned SCALE     = 0
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iARM,
  input  logic                 iVALID,
  input  logic [ADC_WIDTH-1:0] iDATA,
  output logic                 oREADY,
  input  logic                 iFHT_RDY,
  output logic [3:0]           oWE,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oSTART,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic                 oDROP
);

  localparam int unsigned NW = A_BIT + 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    FLUSH   = 3'd2,
    START   = 3'd3,
    WAIT_LO = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t                state_q;
  logic [NW-1:0]         n_q;
  logic [NW-1:0]         n_rev;
  logic                  ready_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  drop_en_q;
  logic [3:0]            we_q;
  logic [D_BIT-1:0]      data_q;
  logic [A_BIT-1:0]      addr_q;
  logic                  accept;
  logic                  last_sample;
  logic signed [ADC_WIDTH-1:0] sample_s;
  logic signed [D_BIT-1:0]     sample_ext;

  always_comb begin
    n_rev = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      n_rev[i] = n_q[NW-1-i];
    end
  end

  // Width rule ADC_WIDTH+SCALE <= D_BIT guarantees the shift never overflows.
  always_comb begin
    sample_s   = iDATA;
    sample_ext = D_BIT'(sample_s) <<< SCALE;
  end

  assign accept      = iVALID & ready_q;
  assign last_sample = (n_q == '1);

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q   <= IDLE;
      n_q       <= '0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_en_q <= 1'b0;
      we_q      <= '0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '0;

      if (accept) begin
        we_q   <= 4'd1 << n_rev[NW-1 -: 2];
        addr_q <= n_rev[A_BIT-1:0];
        data_q <= sample_ext;
        n_q    <= n_q + NW'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (iARM && iFHT_RDY) begin
            state_q   <= FILL;
            n_q       <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            drop_en_q <= 1'b0;
          end
        end
        FILL: begin
          if (accept && last_sample) begin
            state_q   <= FLUSH;
            ready_q   <= 1'b0;
            drop_en_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= START;
          start_q <= 1'b1;
        end
        START: begin
          state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!iFHT_RDY) begin
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (iFHT_RDY) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            drop_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b0;
          busy_q    <= 1'b0;
          drop_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign oREADY   = ready_q;
  assign oWE      = we_q;
  assign oDATA    = data_q;
  assign oADDR_WR = addr_q;
  assign oSTART   = start_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oDROP    = iVALID & drop_en_q;

endmodule

// File: tb/tb_fht_adc_loader.sv
// Directed bench for fht_adc_loader (A_BIT=3, N=32) with a write scoreboard and a
// second SCALE=2 instance for the data-path scaling cases.
module tb_fht_adc_loader;

  logic        clk;
  logic        rst_n;
  logic        arm, valid, fht_rdy;
  logic [15:0] din;
  logic        ready, start, busy, done, drop;
  logic [3:0]  we;
  logic [21:0] dout;
  logic [2:0]  addr;

  logic        arm2, valid2, fht_rdy2;
  logic [15:0] din2;
  logic        ready2, start2, busy2, done2, drop2;
  logic [3:0]  we2;
  logic [21:0] dout2;
  logic [2:0]  addr2;

  fht_adc_loader #(.ADC_WIDTH(16), .D_BIT(22), .A_BIT(3), .SCALE(0)) u_dut (
    .iCLK(clk), .iRESET(rst_n), .iARM(arm), .iVALID(valid), .iDATA(din),
    .oREADY(ready), .iFHT_RDY(fht_rdy), .oWE(we), .oDATA(dout), .oADDR_WR(addr),
    .oSTART(start), .oBUSY(busy), .oDONE(done), .oDROP(drop)
  );

  fht_adc_loader #(.ADC_WIDTH(16), .D_BIT(22), .A_BIT(3), .SCALE(2)) u_s2 (
    .iCLK(clk), .iRESET(rst_n), .iARM(arm2), .iVALID(valid2), .iDATA(din2),
    .oREADY(ready2), .iFHT_RDY(fht_rdy2), .oWE(we2), .oDATA(dout2), .oADDR_WR(addr2),
    .oSTART(start2), .oBUSY(busy2), .oDONE(done2), .oDROP(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  we;
    logic [2:0]  addr;
    logic [21:0] data;
    int          n;
  } wr_t;

  wr_t         sbq[$];
  int          total = 0;
  int          fails = 0;
  int          cyc = 0;
  int          sb_n = 0;
  int          frame_acc = 0;
  int          last_acc_cyc = 0;
  int          start_cyc = 0;
  int          start_cnt = 0;
  int          drop_cnt = 0;
  int          done_cnt = 0;
  logic [21:0] img [4][8];
  int          cnt [4][8];
  logic [21:0] img_ref [4][8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input int n, input logic [15:0] d);
    wr_t        e;
    logic [4:0] nb;
    logic [4:0] r;
    int         v;
    nb = 5'(n);
    for (int i = 0; i < 5; i++) r[i] = nb[4-i];
    v      = int'($signed(d));
    e.we   = 4'b0001 << r[4:3];
    e.addr = r[2:0];
    e.data = v[21:0];
    e.n    = n;
    return e;
  endfunction

  task automatic clear_image();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 8; a++) begin
        img[b][a] = '0;
        cnt[b][a] = 0;
      end
  endtask

  // One clock cycle: observe this cycle's outputs on the falling edge, then advance.
  task automatic step();
    wr_t e;
    int  b;
    @(negedge clk);
    if (we !== 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", {28'd0, we}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wr_we", {28'd0, we}, {28'd0, e.we});
        chk("wr_addr", {29'd0, addr}, {29'd0, e.addr});
        chk("wr_data", {10'd0, dout}, {10'd0, e.data});
        if (e.n == 1) begin
          chk("n1_we", {28'd0, we}, 32'h4);
          chk("n1_addr", {29'd0, addr}, 32'd0);
          chk("n1_data", {10'd0, dout}, 32'd1);
        end
        if (e.n == 3) begin
          chk("n3_we", {28'd0, we}, 32'h8);
          chk("n3_addr", {29'd0, addr}, 32'd0);
        end
        if (e.n == 6) begin
          chk("n6_we", {28'd0, we}, 32'h2);
          chk("n6_addr", {29'd0, addr}, 32'd4);
        end
        b = 0;
        for (int i = 0; i < 4; i++) if (we[i]) b = i;
        img[b][addr] = dout;
        cnt[b][addr]++;
      end
    end
    if (valid && ready) begin
      sbq.push_back(model(sb_n, din));
      sb_n = (sb_n + 1) % 32;
      frame_acc++;
      last_acc_cyc = cyc;
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (drop) drop_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic arm_frame();
    arm = 1'b1;
    step();
    arm = 1'b0;
    sb_n = 0;
    frame_acc = 0;
    clear_image();
  endtask

  task automatic feed(input int count, input bit toggle);
    bit v;
    int budget;
    v = 1'b1;
    budget = 0;
    while (frame_acc < count && budget < 200) begin
      valid = v;
      din   = 16'(sb_n);
      step();
      if (toggle) v = ~v;
      budget++;
    end
    valid = 1'b0;
    chk("feed_budget", (budget < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_start();
    int s0;
    int k;
    s0 = start_cnt;
    k = 0;
    while (start_cnt == s0 && k < 10) begin
      step();
      k++;
    end
    chk("start_seen", 32'(start_cnt - s0), 32'd1);
  endtask

  task automatic wait_done();
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 10) begin
      step();
      k++;
    end
    step();
    step();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_banks();
    int bad;
    int per;
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      per = 0;
      for (int a = 0; a < 8; a++) begin
        per += cnt[b][a];
        if (cnt[b][a] != 1) bad++;
      end
      chk("bank_writes", 32'(per), 32'd8);
    end
    chk("addr_once", 32'(bad), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int s0, d0, p0, mism;
    rst_n = 1'b0; arm = 1'b0; valid = 1'b0; fht_rdy = 1'b1; din = '0;
    arm2 = 1'b0; valid2 = 1'b0; fht_rdy2 = 1'b1; din2 = '0;
    clear_image();
    repeat (3) step();
    chk("rst_we", {28'd0, we}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {10'd0, dout}, 32'd0);
    chk("rst_addr", {29'd0, addr}, 32'd0);
    rst_n = 1'b1;
    step();

    // SCALE=2 instance: extreme samples
    arm2 = 1'b1; step(); arm2 = 1'b0;
    valid2 = 1'b1; din2 = 16'h8000; step();
    chk("s2_min", {10'd0, dout2}, 32'h3E0000);
    chk("s2_we", {28'd0, we2}, 32'h1);
    din2 = 16'h7FFF; step();
    chk("s2_max", {10'd0, dout2}, 32'h01FFFC);
    valid2 = 1'b0;

    // Frame 1: consecutive samples
    arm_frame();
    chk("fill_ready", {31'd0, ready}, 32'd1);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    feed(32, 1'b0);
    wait_start();
    chk("start_latency", 32'(start_cyc - last_acc_cyc), 32'd2);
    step();
    check_banks();
    img_ref = img;
    chk("no_drop_yet", 32'(drop_cnt), 32'd0);

    // FHT busy for 50 cycles while samples keep arriving
    p0 = drop_cnt;
    fht_rdy = 1'b0; valid = 1'b1;
    repeat (50) step();
    valid = 1'b0; fht_rdy = 1'b1;
    chk("drops_in_wait", 32'(drop_cnt - p0), 32'd50);
    wait_done();
    chk("start_once_f1", 32'(start_cnt), 32'd1);

    // Frame 2: iVALID toggling
    s0 = start_cnt;
    arm_frame();
    feed(32, 1'b1);
    wait_start();
    chk("start_latency_tog", 32'(start_cyc - last_acc_cyc), 32'd2);
    fht_rdy = 1'b0; step(); fht_rdy = 1'b1;
    wait_done();
    check_banks();
    mism = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 8; a++)
        if (img[b][a] !== img_ref[b][a]) mism++;
    chk("image_match", 32'(mism), 32'd0);
    chk("start_once_f2", 32'(start_cnt - s0), 32'd1);

    // Reset after 10 accepted samples
    s0 = start_cnt;
    arm_frame();
    feed(10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_we", {28'd0, we}, 32'd0);
    chk("async_ready", {31'd0, ready}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_data", {10'd0, dout}, 32'd0);
    sbq.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("no_start_after_rst", 32'(start_cnt - s0), 32'd0);
    arm_frame();
    valid = 1'b1; din = 16'h1234; step(); valid = 1'b0;
    chk("post_rst_we", {28'd0, we}, 32'h1);
    chk("post_rst_addr", {29'd0, addr}, 32'd0);
    chk("post_rst_data", {10'd0, dout}, 32'h001234);
    step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Arm hold-off while the FHT is not ready
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    fht_rdy = 1'b0; arm = 1'b1;
    repeat (3) step();
    chk("holdoff_ready", {31'd0, ready}, 32'd0);
    chk("holdoff_busy", {31'd0, busy}, 32'd0);
    arm = 1'b0; fht_rdy = 1'b1;
    repeat (2) step();
    chk("arm_not_latched", {31'd0, busy}, 32'd0);
    d0 = done_cnt;
    fht_rdy = 1'b0; arm = 1'b1; step();
    fht_rdy = 1'b1; step(); arm = 1'b0;
    chk("arm_fill_ready", {31'd0, ready}, 32'd1);
    chk("arm_fill_busy", {31'd0, busy}, 32'd1);
    chk("no_spurious_done", 32'(done_cnt - d0), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
